// File: rtl/tug_pkg.sv
// tug_pkg: shared types and constants for the tug-of-war match sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, winner encodings, LFSR width/seed/tap positions.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        HOLD       = 2'd1,
        MATCH_DONE = 2'd2
    } tug_state_e;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b10;
    localparam logic [1:0] WIN_RIGHT = 2'b01;

    // 10-bit Fibonacci LFSR, taps 10 and 7 (bit indices 9 and 6).
    localparam int          LFSR_W     = 10;
    localparam logic [9:0]  LFSR_SEED  = 10'h001;
    localparam int          LFSR_TAP_A = 9;
    localparam int          LFSR_TAP_B = 6;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/tug_lfsr.sv
// tug_lfsr: free-running 10-bit Fibonacci LFSR used as the CPU player's dice.
// Latency: new value every cycle; seeded on synchronous reset.
// Backpressure: none, advances unconditionally.
// Ports: clock, reset (sync, active-high), state_o = current LFSR contents.
module tug_lfsr
    import tug_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/tug_match_ctrl.sv
// tug_match_ctrl: tug-of-war match sequencer; rope position, round wins, scores, hold-off, match end.
// Latency: a press sampled at edge N shows on lights/scores after edge N; all outputs registered.
// Backpressure: none; presses are one-cycle pulses and are dropped outside PLAY.
// Ports: clock, reset (sync, active-high), left_press/right_press pulses in;
//        lights (one-hot rope, MSB = leftmost), left_score/right_score, winner, round_over, match_over out.
// Build option: TUG_CPU_PLAYER_EN adds cpu_level[2:0] and drives the right player from an LFSR;
//        right_press is then ignored.
module tug_match_ctrl
    import tug_pkg::*;
#(
    parameter int NUM_LIGHTS  = 9,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4,
    localparam int SW = $clog2(WIN_SCORE + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  left_press,
    input  logic                  right_press,
`ifdef TUG_CPU_PLAYER_EN
    input  logic [2:0]            cpu_level,
`endif
    output logic [NUM_LIGHTS-1:0] lights,
    output logic [SW-1:0]         left_score,
    output logic [SW-1:0]         right_score,
    output logic [1:0]            winner,
    output logic                  round_over,
    output logic                  match_over
);

    localparam int PW = $clog2(NUM_LIGHTS);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PW-1:0]         POS_MAX      = PW'(NUM_LIGHTS - 1);
    localparam logic [PW-1:0]         POS_CENTER   = PW'(NUM_LIGHTS / 2);
    localparam logic [CW-1:0]         CNT_LAST     = CW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0]         SCORE_MATCH  = SW'(WIN_SCORE);
    localparam logic [NUM_LIGHTS-1:0] LIGHT_ONE    = NUM_LIGHTS'(1);
    localparam logic [NUM_LIGHTS-1:0] LIGHTS_RESET = LIGHT_ONE << POS_CENTER;

    tug_state_e            state_q, state_d;
    logic [PW-1:0]         pos_q, pos_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         lscore_q, lscore_d;
    logic [SW-1:0]         rscore_q, rscore_d;
    logic [1:0]            winner_q, winner_d;
    logic                  round_over_q, round_over_d;
    logic                  match_over_q, match_over_d;
    logic [NUM_LIGHTS-1:0] lights_q, lights_d;

    logic left_eff;
    logic right_eff;
    logic match_won;

    assign left_eff = left_press;

`ifdef TUG_CPU_PLAYER_EN
    logic [LFSR_W-1:0] lfsr_w;
    logic              unused_right_press;
    logic              unused_lfsr_hi;

    tug_lfsr u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .state_o (lfsr_w)
    );

    // CPU presses with probability cpu_level/8 per cycle; level 0 never presses.
    assign right_eff          = (lfsr_w[2:0] < cpu_level);
    assign unused_right_press = right_press;
    assign unused_lfsr_hi     = ^lfsr_w[LFSR_W-1:3];
`else
    assign right_eff = right_press;
`endif

    // The winner recorded at round end selects whose score is tested for the match.
    assign match_won = (winner_q == WIN_LEFT) ? (lscore_q == SCORE_MATCH)
                                              : (rscore_q == SCORE_MATCH);

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        cnt_d        = cnt_q;
        lscore_d     = lscore_q;
        rscore_d     = rscore_q;
        winner_d     = winner_q;
        round_over_d = 1'b0;
        match_over_d = match_over_q;

        unique case (state_q)
            PLAY: begin
                if (left_eff && !right_eff) begin
                    if (pos_q == POS_MAX) begin
                        lscore_d     = lscore_q + 1'b1;
                        winner_d     = WIN_LEFT;
                        round_over_d = 1'b1;
                        cnt_d        = '0;
                        state_d      = HOLD;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else if (right_eff && !left_eff) begin
                    if (pos_q == '0) begin
                        rscore_d     = rscore_q + 1'b1;
                        winner_d     = WIN_RIGHT;
                        round_over_d = 1'b1;
                        cnt_d        = '0;
                        state_d      = HOLD;
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
            end
            HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (match_won) begin
                        match_over_d = 1'b1;
                        state_d      = MATCH_DONE;
                    end else begin
                        pos_d    = POS_CENTER;
                        winner_d = WIN_NONE;
                        state_d  = PLAY;
                    end
                end
            end
            MATCH_DONE: begin
                // Terminal until reset; everything frozen.
            end
            default: begin
                state_d = PLAY;
                pos_d   = POS_CENTER;
            end
        endcase

        // Playfield is dark whenever the rope is not in play.
        lights_d = (state_d == PLAY) ? (LIGHT_ONE << pos_d) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= PLAY;
            pos_q        <= POS_CENTER;
            cnt_q        <= '0;
            lscore_q     <= '0;
            rscore_q     <= '0;
            winner_q     <= WIN_NONE;
            round_over_q <= 1'b0;
            match_over_q <= 1'b0;
            lights_q     <= LIGHTS_RESET;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            cnt_q        <= cnt_d;
            lscore_q     <= lscore_d;
            rscore_q     <= rscore_d;
            winner_q     <= winner_d;
            round_over_q <= round_over_d;
            match_over_q <= match_over_d;
            lights_q     <= lights_d;
        end
    end

    assign lights      = lights_q;
    assign left_score  = lscore_q;
    assign right_score = rscore_q;
    assign winner      = winner_q;
    assign round_over  = round_over_q;
    assign match_over  = match_over_q;

endmodule
